// File: rtl/peripheral_bcdconv.sv
// BCD <-> binary conversion peripheral for the J1 I/O bus.
// Software loads an operand and a mode, pulses START, then polls DONE or
// STATUS and reads RESULT. The conversion is an iterative shift/adjust
// (double-dabble one way, reverse double-dabble the other) that takes one
// clock per operand bit after a single validation cycle.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | no conversion since reset, waiting for START
// S_CHECK | operand latched, validating digits / range, loading counter
// S_SHIFT | one shift/adjust iteration per clock until counter expires
// S_DONE  | result valid, done held high until next START or reset
module peripheral_bcdconv #(
    parameter int NDIG = 5,
    parameter int BINW = 17,
    parameter int AW   = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   d_in,
    input  logic          cs,
    input  logic [AW-1:0] addr,
    input  logic          rd,
    input  logic          wr,
    output logic [31:0]   d_out
);

    localparam int BCDW = 4 * NDIG;
    localparam int OPW  = (BCDW > BINW) ? BCDW : BINW;
    // Shift register: BCD field on top, binary field (OPW wide) below.
    localparam int SRW  = BCDW + OPW;
    localparam int CW   = $clog2(OPW + 1);

    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    localparam logic [31:0] MAXV = 32'(pow10(NDIG) - 1);

    localparam logic [AW-1:0] ADDR_A      = AW'(8'h04);
    localparam logic [AW-1:0] ADDR_MODE   = AW'(8'h08);
    localparam logic [AW-1:0] ADDR_START  = AW'(8'h0C);
    localparam logic [AW-1:0] ADDR_RESULT = AW'(8'h10);
    localparam logic [AW-1:0] ADDR_DONE   = AW'(8'h14);
    localparam logic [AW-1:0] ADDR_STATUS = AW'(8'h18);

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_SHIFT, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [OPW-1:0]  a_reg;
    logic            mode_reg;
    logic [OPW-1:0]  op_w;
    logic            mode_w;
    logic [SRW-1:0]  sr;
    logic [SRW-1:0]  sr_next;
    logic [CW-1:0]   cnt;
    logic [31:0]     result;
    logic            done;
    logic            err;
    logic            busy;
    logic            digit_bad;
    logic            op_bad;
    logic            wr_a;
    logic            wr_mode;
    logic            start;
    logic [31:0]     unused_d_in;

    // Operand bits above OPW are never stored.
    assign unused_d_in = d_in;

    assign wr_a    = cs && wr && (addr == ADDR_A);
    assign wr_mode = cs && wr && (addr == ADDR_MODE);
    assign start   = cs && wr && (addr == ADDR_START) && d_in[0];

    // bin->BCD step: add 3 to every BCD nibble >= 5, then shift left.
    function automatic logic [SRW-1:0] step_b2d(input logic [SRW-1:0] s);
        logic [SRW-1:0] t;
        t = s;
        for (int i = 0; i < NDIG; i++)
            if (t[OPW+4*i +: 4] >= 4'd5) t[OPW+4*i +: 4] = t[OPW+4*i +: 4] + 4'd3;
        return t << 1;
    endfunction

    // BCD->bin step: shift right, then subtract 3 from every BCD nibble >= 8.
    function automatic logic [SRW-1:0] step_d2b(input logic [SRW-1:0] s);
        logic [SRW-1:0] t;
        t = s >> 1;
        for (int i = 0; i < NDIG; i++)
            if (t[OPW+4*i +: 4] >= 4'd8) t[OPW+4*i +: 4] = t[OPW+4*i +: 4] - 4'd3;
        return t;
    endfunction

    assign sr_next = mode_w ? step_b2d(sr) : step_d2b(sr);

    // Operand validation and next-state selection.
    always_comb begin
        state_d   = state_q;
        digit_bad = 1'b0;
        for (int i = 0; i < NDIG; i++)
            if (op_w[4*i +: 4] > 4'd9) digit_bad = 1'b1;
        op_bad = mode_w ? (32'(op_w[BINW-1:0]) > MAXV) : digit_bad;
        unique case (state_q)
            S_IDLE, S_DONE: if (start) state_d = S_CHECK;
            S_CHECK:        state_d = op_bad ? S_DONE : S_SHIFT;
            S_SHIFT:        if (cnt == CW'(1)) state_d = S_DONE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Register file writes and the conversion datapath.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_reg    <= '0;
            mode_reg <= 1'b0;
            op_w     <= '0;
            mode_w   <= 1'b0;
            sr       <= '0;
            cnt      <= '0;
            result   <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            busy     <= 1'b0;
        end else begin
            if (wr_a)    a_reg    <= d_in[OPW-1:0];
            if (wr_mode) mode_reg <= d_in[0];
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        op_w   <= a_reg;
                        mode_w <= mode_reg;
                        done   <= 1'b0;
                        err    <= 1'b0;
                        busy   <= 1'b1;
                    end
                end
                S_CHECK: begin
                    if (op_bad) begin
                        err    <= 1'b1;
                        result <= '0;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                    end else if (mode_w) begin
                        cnt <= CW'(BINW);
                        sr  <= SRW'(op_w[BINW-1:0]) << (OPW - BINW);
                    end else begin
                        cnt <= CW'(BCDW);
                        sr  <= SRW'(op_w[BCDW-1:0]) << OPW;
                    end
                end
                S_SHIFT: begin
                    sr  <= sr_next;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        // Binary value accumulates from the top of the low field.
                        result <= mode_w ? 32'(sr_next[SRW-1 -: BCDW])
                                         : 32'(sr_next[OPW-1 -: BCDW]);
                        done   <= 1'b1;
                        busy   <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Registered read port; unmapped addresses leave d_out untouched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_out <= '0;
        end else if (cs && rd) begin
            case (addr)
                ADDR_A:      d_out <= 32'(a_reg);
                ADDR_MODE:   d_out <= {31'b0, mode_reg};
                ADDR_RESULT: d_out <= result;
                ADDR_DONE:   d_out <= {31'b0, done};
                ADDR_STATUS: d_out <= {30'b0, err, busy};
                default:     ;
            endcase
        end
    end

endmodule

// File: doc/peripheral_bcdconv.md
Name: peripheral_bcdconv

Overview:
- Memory-mapped BCD<->binary conversion peripheral on the J1 I/O bus, with an iterative shift/adjust converter built in.
- Parametrised successor of the fixed 5-digit BCD-to-binary peripheral. Adds:
  - configurable digit count and binary width;
  - a mode bit (BCD->bin or bin->BCD);
  - self-clearing start;
  - busy/error status with invalid-digit and overflow detection.
- Software writes an operand and the mode, writes start, then polls done or status and reads the result.

Parameters:
- NDIG, 5: number of BCD digits. Constraint: 1..8, so 4*NDIG <= 32.
- BINW, 17: binary operand/result width. Constraint: 2^BINW >= 10^NDIG and BINW <= 32.
- AW, 5: address width (the 4 LSBs come from j1_io_addr).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- d_in  in  32  write data bus.
- cs  in  1  peripheral select.
- addr  in  AW  register address.
- rd  in  1  read strobe.
- wr  in  1  write strobe.
- d_out  out  32  registered read data.

Behaviour:
- Register map. A write takes effect only when cs && wr and the address matches.
  - 0x04 A (RW-in): operand. Holds OPW = max(4*NDIG, BINW) bits, taken from d_in[OPW-1:0].
  - 0x08 MODE: d_in[0]. 0 = BCD->bin, 1 = bin->BCD.
  - 0x0C START: write with d_in[0]=1 launches a conversion. This is a pulse, not a stored level.
  - 0x10 RESULT (RO): zero-extended to 32 bits.
  - 0x14 DONE (RO): {31'b0, done}.
  - 0x18 STATUS (RO): {30'b0, err, busy}.
  - Unmapped addresses: writes ignored; reads leave d_out unchanged.
- Reset (reset=0, asynchronous): all of the following clear to 0 immediately, and the FSM goes to IDLE:
  - A, MODE, result, done, err, busy, iteration counter, d_out.
- Read path: d_out loads the selected register on the clk edge where cs && rd. Otherwise it holds its value.
- FSM states: IDLE, CHECK, SHIFT, DONE.
  - IDLE/DONE + START write at edge k: latch A and MODE into the working register; clear done and err; set busy=1; go to CHECK.
  - CHECK (edge k+1), BCD->bin mode: if any nibble in A[4*NDIG-1:0] > 9, set err=1, result=0, done=1, busy=0, go to DONE.
  - CHECK (edge k+1), bin->BCD mode: if A[BINW-1:0] > 10^NDIG-1, apply the same error path.
  - CHECK, otherwise: load counter N (BCD->bin N=4*NDIG; bin->BCD N=BINW) and go to SHIFT.
  - SHIFT, BCD->bin (reverse double-dabble): each edge, shift {bcd,bin} right 1; then subtract 3 from every BCD nibble >= 8.
  - SHIFT, bin->BCD (double-dabble): each edge, add 3 to every BCD nibble >= 5; then shift {bcd,bin} left 1.
  - SHIFT: after exactly N iterations, write result, set done=1, clear busy, go to DONE.
  - DONE: done stays 1 until the next START or reset. Reading does not clear it.
- Latency: done=1 is visible after edge k+1+N, i.e. N+1 cycles after the START write edge. On the error path it is visible after edge k+1.
- Simultaneous events and busy rules:
  - START while busy: ignored.
  - Writes to A/MODE while busy: accepted into the registers, but they do not affect the running conversion, which uses the latched copy.
  - Write and read in the same cycle: the read returns the pre-write value.
  - START with d_in[0]=0: no effect.
- Result widths:
  - BCD->bin result: BINW bits.
  - bin->BCD result: 4*NDIG bits.

Test Plan:
- Reset low mid-SHIFT (BCD->bin, A=0x12345) -> busy, done, err, d_out go to 0 immediately. After release, a new START converts correctly.
- MODE=0, A=0x12345, START -> busy for 21 cycles. DONE reads 1 at cycle 21. RESULT reads 0x00003039; STATUS reads 0.
- MODE=1, A=0x1869F (99999), START -> done after 18 cycles. RESULT reads 0x00099999.
- MODE=0, A=0x1A345 -> done after 2 edges. err=1, RESULT=0, STATUS reads 0x2.
- MODE=1, A=0x186A0 (100000) -> err=1, RESULT=0. Then A=0 with START -> RESULT=0, err cleared.
- START issued at cycle 5 of a running conversion -> ignored. Original result and done timing are unchanged. Read of unmapped address 0x1C -> d_out holds its previous value.
